// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: turns hazard, cache and halt
// indications into PC/latch enables, owns the data-miss wait and halt states.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic             dhit,
  input  logic             disable_fetch,
  input  logic             flush2,
  input  logic             flush3,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dreq;
  logic               advance;

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    advance    = 1'b0;
    state_d    = state_q;
    halt_d     = halt_q;
    cnt_d      = cnt_q;
    dreq       = dmemREN | dmemWEN;

    // A pipeline advance happens unless a data access is still outstanding.
    if (!RST) begin
      case (state_q)
        RUN:     if (dreq && !dhit) state_d = DWAIT; else advance = 1'b1;
        DWAIT:   if (dhit) begin state_d = RUN; advance = 1'b1; end
        HALTED:  ;
        default: state_d = RUN;
      endcase
    end

    if (advance) begin
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (flush2 || flush3) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = flush3;
      end else if (disable_fetch) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
      end
      if (halt_mem) begin
        state_d = HALTED;
        halt_d  = 1'b1;
      end
    end

    if (!RST && state_q != HALTED && !pc_en && !(&cnt_q))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes model predictions, a
// negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0, dhit = 1'b0;
  logic disable_fetch = 1'b0, flush2 = 1'b0, flush3 = 1'b0, halt_mem = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0] state;

  typedef struct {
    logic [6:0] en;
    logic [1:0] st;
    logic       hlt;
    int         cnt;
  } exp_t;

  exp_t expQ[$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;

  // Model state: mode 0 = running, 1 = waiting on data, 2 = halted.
  int mMode = 0;
  bit mHalt = 0;
  int mCnt = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dhit(dhit), .disable_fetch(disable_fetch), .flush2(flush2), .flush3(flush3),
    .halt_mem(halt_mem), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halt(halt), .stall_cnt(stall_cnt), .state(state)
  );

  task automatic applyStimulus(input bit r, input bit ih, input bit rd, input bit wr,
                               input bit dh, input bit df, input bit f2, input bit f3,
                               input bit hm);
    exp_t e;
    bit pc, fi, di, ex, mw, ff, dfl, frozen;
    @(posedge CLK);
    #1;
    RST = r; ihit = ih; dmemREN = rd; dmemWEN = wr; dhit = dh;
    disable_fetch = df; flush2 = f2; flush3 = f3; halt_mem = hm;
    {pc, fi, di, ex, mw, ff, dfl} = 7'b0;
    if (r) begin
      e.st = 2'd0; e.hlt = 1'b0; e.cnt = 0;
      mMode = 0; mHalt = 0; mCnt = 0;
    end else begin
      e.st = 2'(mMode); e.hlt = mHalt; e.cnt = mCnt;
      if (mMode != 2) begin
        frozen = (mMode == 1) ? !dh : ((rd || wr) && !dh);
        if (frozen) mMode = 1;
        else begin
          mMode = 0;
          ex = 1; mw = 1;
          if (f2 || f3) begin pc = 1; fi = 1; di = 1; ff = 1; dfl = f3; end
          else if (df) begin di = 1; dfl = 1; end
          else if (!ih) begin fi = 1; ff = 1; di = 1; end
          else begin pc = 1; fi = 1; di = 1; end
          if (hm) begin mMode = 2; mHalt = 1; end
        end
        if (!pc && mCnt < CNT_MAX) mCnt++;
      end
    end
    e.en = {pc, fi, di, ex, mw, ff, dfl};
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, got, want);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    cycle++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                                   ifid_flush, idex_flush}), int'(e.en));
      checkOutput("state", int'(state), int'(e.st));
      checkOutput("halt", int'(halt), int'(e.hlt));
      checkOutput("stall_cnt", int'(stall_cnt), e.cnt);
    end
  end

  initial begin
    int waitCycles;
    // Reset then a clean fetch cycle.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Load miss for three cycles, then hit.
    repeat (3) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // All hazards at once, then load-use, then fetch miss.
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Halt held behind a store miss; later inputs must be ignored.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // Long fetch miss drives the counter into saturation.
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic with occasional resets and rare halts.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0) || (mMode == 2 && $urandom_range(0, 3) == 0),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 6) == 0, $urandom_range(0, 15) == 0);
    end
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge CLK);
      waitCycles++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
